// File: rtl/countdown_timer.sv
// Loadable down-counting timer with a prescaler, one-shot or periodic reload, and a sticky
// expiry interrupt with an overrun flag.
module countdown_timer #(
   parameter int WIDTH          = 8,
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic                      clock_i,
   input  logic                      reset_ni,
   input  logic                      enable_i,
   input  logic                      load_i,
   input  logic [WIDTH-1:0]          load_value_i,
   input  logic                      start_i,
   input  logic                      stop_i,
   input  logic                      periodic_i,
   input  logic [PRESCALE_WIDTH-1:0] prescale_i,
   input  logic                      irq_ack_i,
   output logic [WIDTH-1:0]          counter_value_o,
   output logic                      running_o,
   output logic                      irq_o,
   output logic                      overrun_o
);

   typedef enum logic {
      IDLE    = 1'b0,
      RUNNING = 1'b1
   } state_e;

   state_e                    state_q, state_d;
   logic [WIDTH-1:0]          count_q, count_d;
   logic [WIDTH-1:0]          reload_q, reload_d;
   logic [PRESCALE_WIDTH-1:0] pc_q, pc_d;
   logic                      irq_q, irq_d;
   logic                      overrun_q, overrun_d;
   logic                      tick;
   logic                      expiry;
   logic                      zero_start;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      count_d    = count_q;
      reload_d   = reload_q;
      pc_d       = pc_q;
      irq_d      = irq_q;
      overrun_d  = overrun_q;
      tick       = 1'b0;
      expiry     = 1'b0;
      zero_start = 1'b0;

      // Acknowledge works even while frozen; a same-edge expiry below overrides it.
      if (irq_ack_i) begin
         irq_d     = 1'b0;
         overrun_d = 1'b0;
      end

      if (enable_i) begin
         tick       = (state_q == RUNNING) && !stop_i && !load_i && (pc_q == prescale_i);
         expiry     = tick && (count_q == WIDTH'(1));
         zero_start = (state_q == IDLE) && start_i && !stop_i && (count_q == '0);

         if (stop_i) begin
            state_d = IDLE;
         end else if (start_i && (state_q == IDLE) && (count_q != '0)) begin
            state_d = RUNNING;
         end

         if (load_i) begin
            count_d  = load_value_i;
            reload_d = load_value_i;
            pc_d     = '0;
         end else if (tick) begin
            pc_d = '0;
            if (count_q > WIDTH'(1)) begin
               count_d = count_q - WIDTH'(1);
            end
         end else if (state_q == RUNNING) begin
            pc_d = pc_q + PRESCALE_WIDTH'(1);
         end

         if (expiry) begin
            irq_d = 1'b1;
            if (irq_q && !irq_ack_i) begin
               overrun_d = 1'b1;
            end
            if (periodic_i) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = IDLE;
            end
         end

         if (zero_start) begin
            irq_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         pc_q      <= '0;
         irq_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         pc_q      <= pc_d;
         irq_q     <= irq_d;
         overrun_q <= overrun_d;
      end
   end

   assign counter_value_o = count_q;
   assign running_o       = (state_q == RUNNING);
   assign irq_o           = irq_q;
   assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: the driver pushes the model's expected state after each
// edge, and an independent monitor pops and compares it one time unit after that edge.
module tb_countdown_timer;

   localparam int WIDTH = 8;
   localparam int PW    = 4;

   logic             clock = 1'b0;
   logic             reset_n = 1'b1;
   logic             enable = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_value = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             periodic = 1'b0;
   logic [PW-1:0]    prescale = '0;
   logic             irq_ack = 1'b0;
   logic [WIDTH-1:0] counter_value;
   logic             running;
   logic             irq;
   logic             overrun;

   countdown_timer #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
      .clock_i        (clock),
      .reset_ni       (reset_n),
      .enable_i       (enable),
      .load_i         (load),
      .load_value_i   (load_value),
      .start_i        (start),
      .stop_i         (stop),
      .periodic_i     (periodic),
      .prescale_i     (prescale),
      .irq_ack_i      (irq_ack),
      .counter_value_o(counter_value),
      .running_o      (running),
      .irq_o          (irq),
      .overrun_o      (overrun)
   );

   always #5 clock = ~clock;

   typedef struct {
      int cnt;
      bit run;
      bit irq;
      bit ovr;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   // Reference model: software-visible timer state kept as plain integers.
   int m_cnt, m_rld, m_pc;
   bit m_run, m_irq, m_ovr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_cnt = 0; m_rld = 0; m_pc = 0;
      m_run = 0; m_irq = 0; m_ovr = 0;
   endfunction

   function automatic void model_step();
      bit old_irq;
      bit old_run;
      bit tick;
      old_irq = m_irq;
      old_run = m_run;
      if (irq_ack) begin
         m_irq = 0;
         m_ovr = 0;
      end
      if (!enable) return;
      tick = old_run && !stop && !load && (m_pc == int'(prescale));
      if (stop) m_run = 0;
      else if (start && !old_run) begin
         if (m_cnt == 0) m_irq = 1;
         else            m_run = 1;
      end
      if (load) begin
         m_cnt = int'(load_value);
         m_rld = int'(load_value);
         m_pc  = 0;
      end else if (tick) begin
         m_pc = 0;
         if (m_cnt > 1) m_cnt = m_cnt - 1;
         else if (m_cnt == 1) begin
            m_irq = 1;
            if (old_irq && !irq_ack) m_ovr = 1;
            if (periodic) m_cnt = m_rld;
            else begin
               m_cnt = 0;
               m_run = 0;
            end
         end
      end else if (old_run) begin
         m_pc = (m_pc + 1) % (1 << PW);
      end
   endfunction

   task automatic apply(input bit en, input bit ld, input int lv, input bit st, input bit sp,
                        input bit per, input int pre, input bit ack);
      exp_t e;
      enable     = en;
      load       = ld;
      load_value = WIDTH'(lv);
      start      = st;
      stop       = sp;
      periodic   = per;
      prescale   = PW'(pre);
      irq_ack    = ack;
      model_step();
      e.cnt = m_cnt;
      e.run = m_run;
      e.irq = m_irq;
      e.ovr = m_ovr;
      sb_q.push_back(e);
   endtask

   task automatic drive(input bit en, input bit ld, input int lv, input bit st, input bit sp,
                        input bit per, input int pre, input bit ack);
      @(negedge clock);
      apply(en, ld, lv, st, sp, per, pre, ack);
   endtask

   task automatic settle();
      @(posedge clock);
      #2;
   endtask

   always @(posedge clock) begin : monitor
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("sb_count",   32'(counter_value), 32'(e.cnt));
         check("sb_running", 32'(running),       32'(e.run));
         check("sb_irq",     32'(irq),           32'(e.irq));
         check("sb_overrun", 32'(overrun),       32'(e.ovr));
      end
   end

   initial begin
      bit per_r;
      int pre_r;

      // Power-on reset.
      #2 reset_n = 1'b0;
      model_reset();
      #2;
      check("reset_count",   32'(counter_value), 32'd0);
      check("reset_running", 32'(running),       32'd0);
      check("reset_irq",     32'(irq),           32'd0);
      check("reset_overrun", 32'(overrun),       32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      apply(1, 0, 0, 0, 0, 0, 0, 0);

      // One-shot: load 3, start, three ticks to expiry.
      drive(1, 1, 3, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0, 0, 0);
      repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("oneshot_count",   32'(counter_value), 32'd0);
      check("oneshot_irq",     32'(irq),           32'd1);
      check("oneshot_running", 32'(running),       32'd0);
      drive(1, 0, 0, 0, 0, 0, 0, 1);

      // Periodic: prescale 1, reload 2, second expiry without ack sets overrun.
      drive(1, 1, 2, 0, 0, 1, 1, 0);
      drive(1, 0, 0, 1, 0, 1, 1, 0);
      repeat (8) drive(1, 0, 0, 0, 0, 1, 1, 0);
      settle();
      check("periodic_count",   32'(counter_value), 32'd2);
      check("periodic_running", 32'(running),       32'd1);
      check("periodic_overrun", 32'(overrun),       32'd1);
      drive(1, 0, 0, 0, 1, 1, 1, 0);

      // Freeze at 5 for ten cycles, ack during the freeze, then resume.
      drive(1, 1, 8, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0, 0, 0);
      repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 0, 0, (i == 4));
      settle();
      check("freeze_count", 32'(counter_value), 32'd5);
      check("freeze_irq",   32'(irq),           32'd0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("resume_count", 32'(counter_value), 32'd4);

      // stop+load+start together; then ack on the expiry edge.
      drive(1, 1, 'hDE, 1, 1, 0, 0, 0);
      settle();
      check("simul_count",   32'(counter_value), 32'hDE);
      check("simul_running", 32'(running),       32'd0);
      drive(1, 1, 1, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 1, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 0, 1);
      settle();
      check("ackwin_irq",     32'(irq),     32'd1);
      check("ackwin_overrun", 32'(overrun), 32'd0);
      drive(1, 0, 0, 0, 1, 1, 0, 0);

      // Asynchronous reset while running at 0x40 with irq set.
      drive(1, 1, 'h40, 0, 0, 0, 15, 0);
      drive(1, 0, 0, 1, 0, 0, 15, 0);
      repeat (3) drive(1, 0, 0, 0, 0, 0, 15, 0);
      @(negedge clock);
      enable = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check("async_count",   32'(counter_value), 32'd0);
      check("async_running", 32'(running),       32'd0);
      check("async_irq",     32'(irq),           32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) drive(1, 0, 0, 0, 0, 0, 0, 0);

      // Zero start: irq without running.
      drive(1, 0, 0, 1, 0, 0, 0, 0);
      settle();
      check("zero_start_irq",     32'(irq),     32'd1);
      check("zero_start_running", 32'(running), 32'd0);
      drive(1, 0, 0, 0, 0, 0, 0, 1);

      // Randomized traffic against the model.
      per_r = 0;
      pre_r = 0;
      for (int i = 0; i < 4000; i++) begin
         int lv;
         if ($urandom_range(0, 199) == 0) per_r = ~per_r;
         if ($urandom_range(0, 49) == 0)
            pre_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
         lv = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 20);
         drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 11) == 0), lv,
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0), per_r, pre_r,
               ($urandom_range(0, 7) == 0));
      end

      repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
